// File: rtl/idecode_pkg.sv
// Shared types, default widths and field-offset helpers for the pipelined instruction decoder.
// Offsets are derived from the parameters so that the decoder and sign extenders stay consistent.
package idecode_pkg;

    typedef enum logic [1:0] {
        SEL_RM   = 2'b00,
        SEL_RD   = 2'b01,
        SEL_RN   = 2'b10,
        SEL_HOLD = 2'b11
    } reg_sel_e;

    localparam int DEF_WORD_W  = 16;
    localparam int DEF_OPC_W   = 3;
    localparam int DEF_RADDR_W = 3;
    localparam int DEF_IMMS_W  = 5;
    localparam int DEF_IMML_W  = 8;

    // LSB positions of each instruction field; the opcode sits at the top of the word.
    function automatic int opc_lsb(input int word_w, input int opc_w);
        return word_w - opc_w;
    endfunction

    function automatic int alu_lsb(input int word_w, input int opc_w);
        return word_w - opc_w - 2;
    endfunction

    function automatic int rn_lsb(input int word_w, input int opc_w, input int raddr_w);
        return word_w - opc_w - 2 - raddr_w;
    endfunction

    function automatic int rd_lsb(input int raddr_w);
        return raddr_w + 2;
    endfunction

    function automatic int shift_lsb(input int raddr_w);
        return raddr_w;
    endfunction

    function automatic int rm_lsb();
        return 0;
    endfunction

endpackage

// File: rtl/sign_ext.sv
// Sign extender: copies the input into the low bits and replicates its MSB upward.
// IN_W must not exceed OUT_W.
module sign_ext #(
    parameter int IN_W  = 5,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  value,
    output logic [OUT_W-1:0] extended
);

    assign extended[IN_W-1:0] = value;

    generate
        for (genvar gi = IN_W; gi < OUT_W; gi++) begin : g_sign
            assign extended[gi] = value[IN_W-1];
        end
    endgenerate

endmodule

// File: rtl/idecode_pipe.sv
// Registered instruction decoder with valid/ready handshakes on both sides and a
// registered register-address port selected by reg_sel.
module idecode_pipe
    import idecode_pkg::*;
#(
    parameter int WORD_W  = DEF_WORD_W,
    parameter int OPC_W   = DEF_OPC_W,
    parameter int RADDR_W = DEF_RADDR_W,
    parameter int IMMS_W  = DEF_IMMS_W,
    parameter int IMML_W  = DEF_IMML_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WORD_W-1:0]  in_instr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPC_W-1:0]   opcode,
    output logic [1:0]         alu_op,
    output logic [1:0]         shift_op,
    output logic [WORD_W-1:0]  sximm5,
    output logic [WORD_W-1:0]  sximm8,
    input  logic [1:0]         reg_sel,
    output logic [RADDR_W-1:0] r_addr,
    output logic [RADDR_W-1:0] w_addr
);

    localparam int OPC_LSB   = opc_lsb(WORD_W, OPC_W);
    localparam int ALU_LSB   = alu_lsb(WORD_W, OPC_W);
    localparam int RN_LSB    = rn_lsb(WORD_W, OPC_W, RADDR_W);
    localparam int RD_LSB    = rd_lsb(RADDR_W);
    localparam int SHIFT_LSB = shift_lsb(RADDR_W);
    localparam int RM_LSB    = rm_lsb();

    logic [WORD_W-1:0]  ir_reg;
    logic               valid_reg;
    logic [RADDR_W-1:0] addr_reg;
    logic [RADDR_W-1:0] addr_next;
    logic               accept;
    logic               drain;
    reg_sel_e           sel;

    assign sel      = reg_sel_e'(reg_sel);
    assign in_ready = !valid_reg || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign drain    = valid_reg && out_ready;

    // Address source is the IR as it stands before any same-cycle load.
    always_comb begin
        addr_next = addr_reg;
        case (sel)
            SEL_RM:   addr_next = ir_reg[RM_LSB +: RADDR_W];
            SEL_RD:   addr_next = ir_reg[RD_LSB +: RADDR_W];
            SEL_RN:   addr_next = ir_reg[RN_LSB +: RADDR_W];
            SEL_HOLD: addr_next = addr_reg;
            default:  addr_next = addr_reg;
        endcase
    end

    // A flushed cycle leaves the IR untouched so the visible fields keep their values.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_reg    <= '0;
            valid_reg <= 1'b0;
            addr_reg  <= '0;
        end else begin
            addr_reg <= addr_next;
            if (flush) begin
                valid_reg <= 1'b0;
            end else if (accept) begin
                ir_reg    <= in_instr;
                valid_reg <= 1'b1;
            end else if (drain) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = valid_reg;
    assign opcode    = ir_reg[OPC_LSB +: OPC_W];
    assign alu_op    = ir_reg[ALU_LSB +: 2];
    assign shift_op  = ir_reg[SHIFT_LSB +: 2];
    assign r_addr    = addr_reg;
    assign w_addr    = addr_reg;

    sign_ext #(
        .IN_W  (IMMS_W),
        .OUT_W (WORD_W)
    ) u_sx5 (
        .value    (ir_reg[IMMS_W-1:0]),
        .extended (sximm5)
    );

    sign_ext #(
        .IN_W  (IMML_W),
        .OUT_W (WORD_W)
    ) u_sx8 (
        .value    (ir_reg[IMML_W-1:0]),
        .extended (sximm8)
    );

endmodule
